// File: rtl/wb_arbiter_if.sv
// Wishbone bundle between N masters, the arbiter and one shared slave.
// The slave modport is the arbiter's view; master is the surrounding system.
interface wb_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
);
    logic [NUM_MASTERS-1:0]              m_cyc_i;
    logic [NUM_MASTERS-1:0]              m_stb_i;
    logic [NUM_MASTERS-1:0]              m_we_i;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_adr_i;
    logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_dat_i;
    logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel_i;
    logic [DATA_WIDTH-1:0]               m_dat_o;
    logic [NUM_MASTERS-1:0]              m_ack_o;
    logic [NUM_MASTERS-1:0]              m_err_o;
    logic                                s_cyc_o;
    logic                                s_stb_o;
    logic                                s_we_o;
    logic [ADDR_WIDTH-1:0]               s_adr_o;
    logic [DATA_WIDTH-1:0]               s_dat_o;
    logic [DATA_WIDTH/8-1:0]             s_sel_o;
    logic [DATA_WIDTH-1:0]               s_dat_i;
    logic                                s_ack_i;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_dat_i, s_ack_i,
        output m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_dat_i, s_ack_i,
        input  m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: N masters share one slave, bus locked per CYC.
// Latency: grant one cycle after request; ACK/data pass through combinationally.
// Backpressure: slave stalls pass to the owner; a watchdog aborts unacknowledged strobes.
module wb_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    wb_arbiter_if.slave                    bus,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_o,
    output logic                           busy_o
);
    localparam int GW = $clog2(NUM_MASTERS);
    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] ABORT = 2'd2;

    logic [1:0]    state;
    logic [GW-1:0] grant;
    logic [GW-1:0] last_grant;
    logic [CW-1:0] wd_cnt;
    logic [GW-1:0] next_grant;

    // First requester found walking upward from the master after last_grant.
    function automatic logic [GW-1:0] pick_next(input logic [GW-1:0] last,
                                                input logic [NUM_MASTERS-1:0] req);
        logic [GW-1:0] win;
        logic          found;
        int            idx;
        win   = last;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = (int'(last) + i) % NUM_MASTERS;
            if (!found && req[idx]) begin
                win   = GW'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign next_grant = pick_next(last_grant, bus.m_cyc_i);
    assign grant_o    = grant;
    assign busy_o     = (state == BUSY);

    always_comb begin
        bus.s_cyc_o = 1'b0;
        bus.s_stb_o = 1'b0;
        bus.s_we_o  = 1'b0;
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_sel_o = '0;
        bus.m_ack_o = '0;
        bus.m_err_o = '0;
        bus.m_dat_o = '0;
        if (state == BUSY) begin
            bus.s_cyc_o        = bus.m_cyc_i[grant];
            bus.s_stb_o        = bus.m_stb_i[grant];
            bus.s_we_o         = bus.m_we_i[grant];
            bus.s_adr_o        = bus.m_adr_i[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
            bus.s_dat_o        = bus.m_dat_i[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
            bus.s_sel_o        = bus.m_sel_i[int'(grant)*SW +: SW];
            bus.m_ack_o[grant] = bus.s_ack_i;
            bus.m_dat_o        = bus.s_dat_i;
        end else if (state == ABORT) begin
            bus.m_err_o[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(NUM_MASTERS - 1);
            wd_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.m_cyc_i) begin
                        grant  <= next_grant;
                        state  <= BUSY;
                        wd_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (!bus.m_cyc_i[grant]) begin
                        last_grant <= grant;
                        state      <= IDLE;
                        wd_cnt     <= '0;
                    end else if (bus.s_ack_i || !bus.s_stb_o) begin
                        wd_cnt <= '0;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        // An ACK on the would-be final cycle is handled above and wins.
                        if (wd_cnt == TO_LAST) begin
                            state  <= ABORT;
                            wd_cnt <= '0;
                        end else begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
                    end
                end
                ABORT: begin
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations, then random
// traffic, all outputs compared every cycle against a behavioural bus-ownership model.
module tb_wb_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [0:0] grant;
    logic       busy;
    int         checks = 0;
    int         errors = 0;
    bit         chk_en = 1'b0;

    wb_arbiter_if #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    wb_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave),
        .grant_o(grant),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 = bus free, 1 = owned, 2 = error-pulse cycle.
    int ph = 0, owner = 0, last = N - 1, stall = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            ph = 0; owner = 0; last = N - 1; stall = 0;
        end else if (ph == 0) begin
            if (bus.m_cyc_i != '0) begin
                for (int j = N; j >= 1; j--)
                    if (bus.m_cyc_i[(last + j) % N]) owner = (last + j) % N;
                ph = 1; stall = 0;
            end
        end else if (ph == 1) begin
            if (!bus.m_cyc_i[owner]) begin
                last = owner; ph = 0;
            end else if (bus.m_stb_i[owner] && !bus.s_ack_i) begin
                stall++;
                if (stall >= TO) begin ph = 2; stall = 0; end
            end else begin
                stall = 0;
            end
        end else begin
            last = owner; ph = 0;
        end
    end

    logic          e_cyc, e_stb, e_we;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat, e_mdat;
    logic [SW-1:0] e_sel;
    logic [N-1:0]  e_ack, e_err;

    always @(negedge clk) begin
        if (chk_en) begin
            e_cyc = 0; e_stb = 0; e_we = 0; e_adr = '0; e_dat = '0; e_sel = '0;
            e_ack = '0; e_err = '0; e_mdat = '0;
            if (ph == 1) begin
                e_cyc = bus.m_cyc_i[owner];
                e_stb = bus.m_stb_i[owner];
                e_we  = bus.m_we_i[owner];
                e_adr = bus.m_adr_i[owner*AW +: AW];
                e_dat = bus.m_dat_i[owner*DW +: DW];
                e_sel = bus.m_sel_i[owner*SW +: SW];
                e_ack[owner] = bus.s_ack_i;
                e_mdat = bus.s_dat_i;
                check("m_grant", grant, owner);
            end else if (ph == 2) begin
                e_err[owner] = 1'b1;
            end
            check("m_busy", busy, ph == 1);
            check("m_s_cyc", bus.s_cyc_o, e_cyc);
            check("m_s_stb", bus.s_stb_o, e_stb);
            check("m_s_we",  bus.s_we_o,  e_we);
            check("m_s_adr", bus.s_adr_o, e_adr);
            check("m_s_dat", bus.s_dat_o, e_dat);
            check("m_s_sel", bus.s_sel_o, e_sel);
            check("m_ack",   bus.m_ack_o, e_ack);
            check("m_err",   bus.m_err_o, e_err);
            check("m_dat",   bus.m_dat_o, e_mdat);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input logic c, input logic s, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] sl);
        bus.m_cyc_i[i]         = c;
        bus.m_stb_i[i]         = s;
        bus.m_we_i[i]          = w;
        bus.m_adr_i[i*AW +: AW] = a;
        bus.m_dat_i[i*DW +: DW] = d;
        bus.m_sel_i[i*SW +: SW] = sl;
    endtask

    int ack_pct;

    initial begin
        bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_we_i = '0;
        bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0;
        bus.s_ack_i = 1'b0; bus.s_dat_i = '0;
        rst_n = 1'b0;
        tick(); tick();
        chk_en = 1'b1;
        check("rst_busy",  busy, 0);
        check("rst_grant", grant, 0);
        check("rst_s_cyc", bus.s_cyc_o, 0);
        check("rst_ack",   bus.m_ack_o, 0);
        check("rst_err",   bus.m_err_o, 0);
        check("rst_m_dat", bus.m_dat_o, 0);
        rst_n = 1'b1;

        // Single requester
        set_m(1, 1, 1, 1, 32'h10, 32'hA5A5A5A5, 4'hF);
        tick();
        check("single_s_cyc", bus.s_cyc_o, 1);
        check("single_adr",   bus.s_adr_o, 32'h10);
        check("single_dat",   bus.s_dat_o, 32'hA5A5A5A5);
        check("single_grant", grant, 1);
        bus.s_ack_i = 1'b1; #1;
        check("single_ack", bus.m_ack_o, 2'b10);
        tick();
        bus.s_ack_i = 1'b0; set_m(1, 0, 0, 0, 0, 0, 0);
        tick();
        check("single_release", busy, 0);

        // Simultaneous requests right after reset
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        set_m(0, 1, 1, 0, 32'h20, 0, 4'hF);
        set_m(1, 1, 1, 0, 32'h30, 0, 4'hF);
        tick();
        check("tie_grant0", grant, 0);
        check("tie_adr0",   bus.s_adr_o, 32'h20);
        set_m(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("tie_gap_busy",  busy, 0);
        check("tie_gap_s_cyc", bus.s_cyc_o, 0);
        tick();
        check("tie_busy1",  busy, 1);
        check("tie_grant1", grant, 1);
        set_m(1, 0, 0, 0, 0, 0, 0);
        tick();

        // Fairness: both request continuously, one transfer per ownership
        set_m(0, 1, 1, 0, 32'h100, 0, 4'hF);
        set_m(1, 1, 1, 0, 32'h200, 0, 4'hF);
        tick();
        for (int i = 0; i < 8; i++) begin
            check("fair_grant", grant, i % 2);
            bus.s_ack_i = 1'b1;
            tick();
            bus.s_ack_i = 1'b0;
            bus.m_cyc_i[i % 2] = 1'b0;
            tick();
            bus.m_cyc_i[i % 2] = 1'b1;
            tick();
        end
        bus.m_cyc_i = '0; bus.m_stb_i = '0;
        tick();

        // Locked reads by master 0 while master 1 waits
        set_m(0, 1, 1, 0, 32'h40, 0, 4'hF);
        tick();
        set_m(1, 1, 1, 0, 32'h50, 0, 4'hF);
        for (int k = 0; k < 3; k++) begin
            bus.s_dat_i = 32'h11 * (k + 1);
            bus.s_ack_i = 1'b1; #1;
            check("lock_ack",   bus.m_ack_o, 2'b01);
            check("lock_dat",   bus.m_dat_o, 32'h11 * (k + 1));
            check("lock_grant", grant, 0);
            tick();
            bus.s_ack_i = 1'b0;
            tick();
        end
        set_m(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("lock_release", busy, 0);
        tick();
        check("lock_next_grant", grant, 1);

        // Timeout: master 1 stalls, master 0 waiting
        set_m(0, 1, 1, 0, 32'h44, 0, 4'hF);
        tick(); tick(); tick();
        check("to_busy_c4", busy, 1);
        tick();
        check("to_abort_busy", busy, 0);
        check("to_abort_err",  bus.m_err_o, 2'b10);
        check("to_abort_cyc",  bus.s_cyc_o, 0);
        set_m(1, 0, 0, 0, 0, 0, 0);
        tick();
        check("to_idle_err",  bus.m_err_o, 0);
        check("to_idle_busy", busy, 0);
        tick();
        check("to_next_grant", grant, 0);

        // ACK on the final cycle beats the watchdog
        tick(); tick(); tick();
        bus.s_ack_i = 1'b1;
        tick();
        check("ackwin_busy", busy, 1);
        check("ackwin_err",  bus.m_err_o, 0);
        bus.s_ack_i = 1'b0;
        tick(); tick(); tick();
        check("ackwin_restart", busy, 1);
        set_m(0, 0, 0, 0, 0, 0, 0);
        tick();

        // Reset while master 1 owns the bus
        set_m(1, 1, 1, 1, 32'h60, 32'h1234, 4'hF);
        tick();
        check("rmid_grant1", grant, 1);
        rst_n = 1'b0; bus.s_ack_i = 1'b1;
        tick();
        check("rmid_busy",  busy, 0);
        check("rmid_ack",   bus.m_ack_o, 0);
        check("rmid_err",   bus.m_err_o, 0);
        check("rmid_s_cyc", bus.s_cyc_o, 0);
        check("rmid_grant", grant, 0);
        rst_n = 1'b1; bus.s_ack_i = 1'b0;
        set_m(0, 1, 1, 0, 32'h70, 0, 4'hF);
        tick();
        check("rmid_tie_grant", grant, 0);
        bus.m_cyc_i = '0; bus.m_stb_i = '0;
        tick();

        // Random traffic against the model
        ack_pct = 35;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) ack_pct = ($urandom_range(0, 2) == 0) ? 0 : 35;
            for (int i = 0; i < N; i++) begin
                if (bus.m_cyc_i[i]) begin
                    if ($urandom_range(0, 5) == 0) bus.m_cyc_i[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    bus.m_cyc_i[i] = 1'b1;
                end
                bus.m_stb_i[i] = bus.m_cyc_i[i] && ($urandom_range(0, 3) != 0);
                bus.m_we_i[i]  = 1'($urandom_range(0, 1));
                bus.m_adr_i[i*AW +: AW] = $urandom;
                bus.m_dat_i[i*DW +: DW] = $urandom;
                bus.m_sel_i[i*SW +: SW] = 4'($urandom_range(0, 15));
            end
            bus.s_ack_i = ($urandom_range(0, 99) < ack_pct);
            bus.s_dat_i = $urandom;
            rst_n = ($urandom_range(0, 399) != 0);
            tick();
        end
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
